// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU data-port memory path.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } memState_t;

  localparam int WORD_BYTES = 4;

  // Major opcodes the CPU decodes into req_write.
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-port request/response bundle; master is the CPU, slave the memory.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder_wait_counter.sv
// Wait-state down-counter: load on accept, count down to zero, flag zero.
module wait_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             dec,
  output logic             zero
);
  logic [WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (reset)                      count <= '0;
    else if (load)                  count <= loadValue;
    else if (dec && count != '0)    count <= count - 1'b1;
  end

  assign zero = (count == '0);
endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with programmable wait states.
module data_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic                 clock,
  input logic                 reset,
  data_mem_responder_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int SHIFT = $clog2(WORD_BYTES);

  memState_t        state, stateNext;
  logic             accept, commit, cntZero;
  logic             latWrite;
  logic [31:0]      latAddr, latWdata;
  logic             readyQ, validQ, errQ;
  logic [31:0]      rdataQ;
  logic [31:0]      offset, wordIdx;
  logic             addrErr;
  logic [IDX_W-1:0] memIdx;

  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  // The below-base test keeps a wrapped subtraction from aliasing into range.
  assign offset  = latAddr - BASE_ADDR;
  assign wordIdx = offset >> SHIFT;
  assign addrErr = (latAddr[SHIFT-1:0] != '0) || (latAddr < BASE_ADDR) ||
                   (wordIdx >= 32'(DEPTH_WORDS));
  assign memIdx  = wordIdx[IDX_W-1:0];

  wait_counter #(.WIDTH(4)) waitCnt (
    .clock     (clock),
    .reset     (reset),
    .load      (accept),
    .loadValue (4'(WAIT_CYCLES)),
    .dec       (state == WAIT && !cntZero),
    .zero      (cntZero)
  );

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    commit    = 1'b0;
    unique case (state)
      IDLE: if (bus.req_valid) begin
        accept    = 1'b1;
        stateNext = WAIT;
      end
      WAIT: if (cntZero) begin
        commit    = 1'b1;
        stateNext = RESP;
      end
      RESP: if (bus.resp_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      readyQ   <= 1'b1;
      validQ   <= 1'b0;
      rdataQ   <= '0;
      errQ     <= 1'b0;
      latWrite <= 1'b0;
      latAddr  <= '0;
      latWdata <= '0;
    end else begin
      state  <= stateNext;
      readyQ <= (stateNext == IDLE);
      validQ <= (stateNext == RESP);
      if (accept) begin
        latWrite <= bus.req_write;
        latAddr  <= bus.req_addr;
        latWdata <= bus.req_wdata;
      end
      if (commit) begin
        errQ   <= addrErr;
        rdataQ <= (latWrite || addrErr) ? '0 : mem[memIdx];
      end else if (state == RESP && bus.resp_ready) begin
        errQ   <= 1'b0;
        rdataQ <= '0;
      end
    end
  end

  // Reset on the commit edge suppresses the store.
  always_ff @(posedge clock) begin
    if (!reset && commit && latWrite && !addrErr) mem[memIdx] <= latWdata;
  end

  assign bus.req_ready  = readyQ;
  assign bus.resp_valid = validQ;
  assign bus.resp_rdata = rdataQ;
  assign bus.resp_err   = errQ;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: five responder instances with differing wait states / base.
module tb_data_mem_responder;
  localparam int N = 5;
  // instance:               4          3       2       1       0
  localparam logic [N-1:0][3:0]  WCS    = {4'd1,      4'd15,  4'd3,   4'd0,   4'd1};
  localparam logic [N-1:0][31:0] BASES  = {32'h1000,  32'h0,  32'h0,  32'h0,  32'h0};
  localparam logic [N-1:0][31:0] DEPTHS = {32'd16,    32'd256,32'd256,32'd256,32'd256};

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  reqValid = '0;
  logic          reqWrite = 1'b0;
  logic [31:0]   reqAddr  = '0;
  logic [31:0]   reqWdata = '0;
  logic          respReady = 1'b0;
  logic [N-1:0]  reqReady, respValid, respErr;
  logic [31:0]   respRdata [N];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < N; g++) begin : gDut
    data_mem_responder_if bus();
    assign bus.req_valid  = reqValid[g];
    assign bus.req_write  = reqWrite;
    assign bus.req_addr   = reqAddr;
    assign bus.req_wdata  = reqWdata;
    assign bus.resp_ready = respReady;
    assign reqReady[g]    = bus.req_ready;
    assign respValid[g]   = bus.resp_valid;
    assign respRdata[g]   = bus.resp_rdata;
    assign respErr[g]     = bus.resp_err;
    data_mem_responder #(
      .DEPTH_WORDS (int'(DEPTHS[g])),
      .WAIT_CYCLES (int'(WCS[g])),
      .BASE_ADDR   (BASES[g])
    ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic startReq(input int sel, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata);
    reqValid[sel] = 1'b1;
    reqWrite      = wr;
    reqAddr       = addr;
    reqWdata      = wdata;
    tick();
    reqValid[sel] = 1'b0;
  endtask

  task automatic waitResp(input int sel, output int lat);
    lat = 0;
    while (!respValid[sel] && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic doTxn(input int sel, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic err, output int lat);
    startReq(sel, wr, addr, wdata);
    waitResp(sel, lat);
    rdata = respRdata[sel];
    err   = respErr[sel];
    respReady = 1'b1;
    tick();
    respReady = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [31:0] pat [4] = '{32'h0101_0101, 32'h2222_3333, 32'h4444_5555, 32'hF00D_CAFE};

  initial begin
    repeat (3) tick();
    reset = 1'b0;

    chk("rst_req_ready",  32'(reqReady[0]),  32'd1);
    chk("rst_resp_valid", 32'(respValid[0]), 32'd0);
    chk("rst_rdata",      respRdata[0],      32'd0);
    chk("rst_err",        32'(respErr[0]),   32'd0);

    // Basic round trip, WAIT_CYCLES=1
    doTxn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
    chk("st_lat",   32'(lat), 32'd2);
    chk("st_rdata", rd,       32'd0);
    chk("st_err",   32'(er),  32'd0);
    doTxn(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("ld_lat",   32'(lat), 32'd2);
    chk("ld_rdata", rd,       32'hDEAD_BEEF);
    chk("ld_err",   32'(er),  32'd0);

    // Latency sweep
    doTxn(1, 1'b1, 32'h4, 32'h1, rd, er, lat);
    chk("lat_w0",  32'(lat), 32'd1);
    doTxn(2, 1'b1, 32'h4, 32'h3, rd, er, lat);
    chk("lat_w3",  32'(lat), 32'd4);
    doTxn(3, 1'b1, 32'h4, 32'hF, rd, er, lat);
    chk("lat_w15", 32'(lat), 32'd16);
    doTxn(3, 1'b0, 32'h4, 32'h0, rd, er, lat);
    chk("lat_w15_ld", rd, 32'hF);

    // Errors
    doTxn(0, 1'b0, 32'h12, 32'h0, rd, er, lat);
    chk("mis_err",   32'(er), 32'd1);
    chk("mis_rdata", rd,      32'd0);
    chk("mis_lat",   32'(lat), 32'd2);
    doTxn(0, 1'b1, 32'h0, 32'h1111_1111, rd, er, lat);
    doTxn(0, 1'b1, 32'h400, 32'h9999_9999, rd, er, lat);
    chk("oor_err",   32'(er), 32'd1);
    chk("oor_rdata", rd,      32'd0);
    doTxn(0, 1'b0, 32'h0, 32'h0, rd, er, lat);
    chk("oor_alias", rd, 32'h1111_1111);

    // Non-zero base: below base, last word, one past end
    doTxn(4, 1'b0, 32'h0FFC, 32'h0, rd, er, lat);
    chk("base_below_err", 32'(er), 32'd1);
    doTxn(4, 1'b1, 32'h103C, 32'h7777_8888, rd, er, lat);
    chk("base_last_err", 32'(er), 32'd0);
    doTxn(4, 1'b0, 32'h103C, 32'h0, rd, er, lat);
    chk("base_last_rd", rd, 32'h7777_8888);
    doTxn(4, 1'b0, 32'h1040, 32'h0, rd, er, lat);
    chk("base_end_err", 32'(er), 32'd1);

    // Backpressure with a request pulse during RESP
    startReq(0, 1'b0, 32'h10, 32'h0);
    waitResp(0, lat);
    chk("bp_lat", 32'(lat), 32'd2);
    for (int k = 0; k < 5; k++) begin
      reqValid[0] = (k == 2);
      if (k == 2) reqAddr = 32'h0;
      chk("bp_valid", 32'(respValid[0]), 32'd1);
      chk("bp_rdata", respRdata[0],      32'hDEAD_BEEF);
      chk("bp_err",   32'(respErr[0]),   32'd0);
      chk("bp_ready", 32'(reqReady[0]),  32'd0);
      tick();
    end
    reqValid[0] = 1'b0;
    respReady   = 1'b1;
    tick();
    respReady   = 1'b0;
    chk("bp_drop_valid", 32'(respValid[0]), 32'd0);
    chk("bp_drop_rdata", respRdata[0],      32'd0);
    chk("bp_idle_ready", 32'(reqReady[0]),  32'd1);
    repeat (3) tick();
    chk("bp_no_accept", 32'(respValid[0]), 32'd0);

    // Reset two edges after accepting a store, WAIT_CYCLES=3
    doTxn(2, 1'b1, 32'h20, 32'hA5A5_A5A5, rd, er, lat);
    startReq(2, 1'b1, 32'h20, 32'h1234_5678);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_req_ready",  32'(reqReady[2]),  32'd1);
    chk("rm_resp_valid", 32'(respValid[2]), 32'd0);
    chk("rm_rdata",      respRdata[2],      32'd0);
    chk("rm_err",        32'(respErr[2]),   32'd0);
    repeat (5) tick();
    chk("rm_quiet", 32'(respValid[2]), 32'd0);
    doTxn(2, 1'b0, 32'h20, 32'h0, rd, er, lat);
    chk("rm_old_value", rd, 32'hA5A5_A5A5);

    // Reset on the commit edge, WAIT_CYCLES=0
    doTxn(1, 1'b1, 32'h30, 32'hCAFE_F00D, rd, er, lat);
    startReq(1, 1'b1, 32'h30, 32'hBAD0_BAD0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rc_resp_valid", 32'(respValid[1]), 32'd0);
    doTxn(1, 1'b0, 32'h30, 32'h0, rd, er, lat);
    chk("rc_old_value", rd, 32'hCAFE_F00D);

    // Back-to-back: 4 stores then 4 loads, resp_ready tied high
    begin
      int          i = 0;
      int          nr = 0;
      int          cyc = 0;
      int          accCyc [8];
      logic [31:0] got [8];
      logic        acc;
      respReady = 1'b1;
      while ((i < 8 || nr < 8) && cyc < 200) begin
        if (i < 8) begin
          reqValid[0] = 1'b1;
          reqWrite    = (i < 4);
          reqAddr     = 32'(4 * (i % 4));
          reqWdata    = pat[i % 4];
        end else begin
          reqValid[0] = 1'b0;
        end
        acc = reqReady[0] && reqValid[0];
        tick();
        cyc++;
        if (acc) begin
          accCyc[i] = cyc;
          i++;
        end
        if (respValid[0] && nr < 8) begin
          got[nr] = respRdata[0];
          nr++;
        end
      end
      reqValid[0] = 1'b0;
      respReady   = 1'b0;
      chk("b2b_count", 32'(nr), 32'd8);
      for (int j = 0; j < 7; j++)
        chk($sformatf("b2b_spacing%0d", j), 32'(accCyc[j+1] - accCyc[j]), 32'd4);
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("b2b_st%0d", j), got[j],   32'd0);
        chk($sformatf("b2b_ld%0d", j), got[j+4], pat[j]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
